// File: rtl/wb_stage.sv
// Writeback stage: captures one instruction from MEM, waits for load data, drives the register file write port.
// Latency: non-load commits the cycle after accept; a load commits the cycle after rvalid (at least 2 cycles after accept).
// Backpressure: m_ready drops only while a load waits; COMMIT can accept a new instruction for 1/cycle throughput.
//
// Ports: clk/rst_in (async active-low); m_* MEM-stage handshake and fields; dmem_rvalid/dmem_rdata load return;
//        WE3/A3/WD3 register file write port; fwd_* forwarding copy of the write; instret retire count;
//        err_timeout sticky flag set when a load is abandoned.
module wb_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_rd,
  input  logic        m_reg_write,
  input  logic [1:0]  m_result_src,
  input  logic [2:0]  m_funct3,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_pc_plus4,
  input  logic [31:0] m_imm,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        WE3,
  output logic [4:0]  A3,
  output logic [31:0] WD3,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] instret,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [4:0]  rd_q;
  logic        reg_write_q;
  logic [1:0]  result_src_q;
  logic [2:0]  funct3_q;
  logic [31:0] data_q;   // holds the load address while waiting, then the extended load data
  logic [7:0]  cnt;

  logic        accept;
  logic [31:0] op_sel;
  logic        in_commit;

  // Byte/half select and extension; addr[0] is ignored for halves.
  function automatic logic [31:0] load_ext(input logic [31:0] w,
                                           input logic [1:0]  a,
                                           input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  assign m_ready   = (state != WAIT_LOAD);
  assign accept    = m_valid & m_ready;
  assign in_commit = (state == COMMIT);

  // Loads capture the address here; it is replaced by the extended data on rvalid.
  always_comb begin
    op_sel = m_alu_result;
    case (m_result_src)
      2'b10:   op_sel = m_pc_plus4;
      2'b11:   op_sel = m_imm;
      default: op_sel = m_alu_result;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state        <= IDLE;
      rd_q         <= 5'd0;
      reg_write_q  <= 1'b0;
      result_src_q <= 2'd0;
      funct3_q     <= 3'd0;
      data_q       <= 32'd0;
      cnt          <= 8'd0;
      instret      <= 32'd0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            data_q <= load_ext(dmem_rdata, data_q[1:0], funct3_q);
            state  <= COMMIT;
          end else if (cnt == CNT_LAST) begin
            // Abandon the load: no write, no retire.
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          if (state == COMMIT) begin
            instret <= instret + 32'd1;
          end
          if (accept) begin
            rd_q         <= m_rd;
            reg_write_q  <= m_reg_write;
            result_src_q <= m_result_src;
            funct3_q     <= m_funct3;
            data_q       <= op_sel;
            cnt          <= 8'd0;
            state        <= (m_result_src == 2'b01) ? WAIT_LOAD : COMMIT;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // result_src is kept for visibility of the committed instruction type; only data_q feeds WD3.
  logic unused_src;
  assign unused_src = ^result_src_q;

  assign WE3       = in_commit & reg_write_q & (rd_q != 5'd0);
  assign A3        = in_commit ? rd_q : 5'd0;
  assign WD3       = in_commit ? data_q : 32'd0;
  assign fwd_valid = WE3;
  assign fwd_rd    = A3;
  assign fwd_data  = WD3;

endmodule
